// File: rtl/axis_hdr_pkg.sv
// Shared types and byte-lane helpers for the header strip stage.
// The stream width is fixed here; the top-level parameters default to these values.
package axis_hdr_pkg;

   localparam int AXIS_DATA_WD = 32;
   localparam int AXIS_BYTE_WD = AXIS_DATA_WD / 8;
   localparam int AXIS_CNT_WD  = $clog2(AXIS_BYTE_WD);

   // One extra bit so a count can hold a full beat (0..AXIS_BYTE_WD).
   typedef logic [AXIS_CNT_WD:0]    byte_cnt_t;
   typedef logic [AXIS_DATA_WD-1:0] data_t;
   typedef logic [AXIS_BYTE_WD-1:0] keep_t;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FIRST = 2'd1;
   localparam logic [1:0] ST_BODY  = 2'd2;
   localparam logic [1:0] ST_FLUSH = 2'd3;

   function automatic keep_t keep_ones(input byte_cnt_t cnt);
      keep_t k;
      for (int i = 0; i < AXIS_BYTE_WD; i++) k[AXIS_BYTE_WD-1-i] = (i < int'(cnt));
      return k;
   endfunction

   function automatic data_t keep_mask(input keep_t k);
      data_t m;
      for (int i = 0; i < AXIS_BYTE_WD; i++) m[8*i +: 8] = {8{k[i]}};
      return m;
   endfunction

   function automatic byte_cnt_t keep_cnt(input keep_t k);
      byte_cnt_t c;
      c = '0;
      for (int i = 0; i < AXIS_BYTE_WD; i++) c = c + byte_cnt_t'(k[i]);
      return c;
   endfunction

   function automatic data_t byte_shl(input data_t d, input byte_cnt_t n);
      return d << (8 * n);
   endfunction

   function automatic data_t byte_shr(input data_t d, input byte_cnt_t n);
      return d >> (8 * n);
   endfunction

endpackage

// File: rtl/axis_out_reg.sv
// One-entry registered output slot; push is only issued while the slot is empty or draining.
module axis_out_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] din,
   output logic         valid,
   output logic [W-1:0] dout,
   input  logic         ready
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         dout  <= '0;
      end else if (push) begin
         valid <= 1'b1;
         dout  <= din;
      end else if (ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/axi_stream_strip_header.sv
// Removes n leading header bytes per packet and realigns the payload to the MSB lane.
// Define STRIP_HDR_OUT_EN to expose the stripped header on a side stream.
module axi_stream_strip_header
   import axis_hdr_pkg::*;
#(
   parameter int DATA_WD      = AXIS_DATA_WD,
   parameter int DATA_BYTE_WD = DATA_WD / 8,
   parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    valid_cfg,
   input  logic [BYTE_CNT_WD-1:0]  strip_cnt,
   output logic                    ready_cfg,
   input  logic                    valid_in,
   input  logic [DATA_WD-1:0]      data_in,
   input  logic [DATA_BYTE_WD-1:0] keep_in,
   input  logic                    last_in,
   output logic                    ready_in,
   output logic                    valid_out,
   output logic [DATA_WD-1:0]      data_out,
   output logic [DATA_BYTE_WD-1:0] keep_out,
   output logic                    last_out,
   input  logic                    ready_out,
   output logic [1:0]              dbg_state
`ifdef STRIP_HDR_OUT_EN
   ,
   output logic                    valid_hdr,
   output logic [DATA_WD-1:0]      data_hdr,
   output logic [DATA_BYTE_WD-1:0] keep_hdr,
   input  logic                    ready_hdr
`endif
);

   localparam int PW = DATA_WD + DATA_BYTE_WD + 1;

   logic [1:0] state;
   byte_cnt_t  n_q, rv_q, k_in, rv_new, r_cnt, body_cnt;
   data_t      res_q, res_new, body_data;
   logic       out_free, hdr_free, acc, pay_push;
   logic [PW-1:0] pay_din, pay_dout;

   always_comb begin
      out_free  = ~valid_out | ready_out;
      ready_cfg = (state == ST_IDLE);
      ready_in  = (((state == ST_FIRST) & hdr_free) | (state == ST_BODY)) & out_free;
      acc       = valid_in & ready_in;
      k_in      = keep_cnt(keep_in);
      rv_new    = (k_in > n_q) ? k_in - n_q : '0;
      res_new   = byte_shl(data_in, n_q);
      r_cnt     = byte_cnt_t'(DATA_BYTE_WD) - n_q;
      body_cnt  = r_cnt + ((k_in < n_q) ? k_in : n_q);
      // Residual fills the top r lanes; the new beat's first n bytes slot in below it.
      body_data = res_q | byte_shr(data_in, r_cnt);
      pay_push  = 1'b0;
      pay_din   = '0;
      case (state)
         ST_FIRST: if (acc && last_in && rv_new != '0) begin
            pay_push = 1'b1;
            pay_din  = {1'b1, keep_ones(rv_new), res_new & keep_mask(keep_ones(rv_new))};
         end
         ST_BODY: if (acc) begin
            pay_push = 1'b1;
            pay_din  = {last_in && (rv_new == '0), keep_ones(body_cnt),
                        body_data & keep_mask(keep_ones(body_cnt))};
         end
         ST_FLUSH: if (out_free) begin
            pay_push = 1'b1;
            pay_din  = {1'b1, keep_ones(rv_q), res_q & keep_mask(keep_ones(rv_q))};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         n_q   <= '0;
         rv_q  <= '0;
         res_q <= '0;
      end else begin
         case (state)
            ST_IDLE: if (valid_cfg) begin
               n_q   <= {1'b0, strip_cnt};
               state <= ST_FIRST;
            end
            ST_FIRST: if (acc) begin
               res_q <= res_new;
               rv_q  <= rv_new;
               state <= last_in ? ST_IDLE : ST_BODY;
            end
            ST_BODY: if (acc) begin
               res_q <= res_new;
               rv_q  <= rv_new;
               if (last_in) state <= (rv_new == '0) ? ST_IDLE : ST_FLUSH;
            end
            ST_FLUSH: if (out_free) begin
               res_q <= '0;
               rv_q  <= '0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign dbg_state = state;

   axis_out_reg #(.W(PW)) u_pay_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (pay_push),
      .din   (pay_din),
      .valid (valid_out),
      .dout  (pay_dout),
      .ready (ready_out)
   );
   assign {last_out, keep_out, data_out} = pay_dout;

`ifdef STRIP_HDR_OUT_EN
   logic hdr_push;
   logic [DATA_WD+DATA_BYTE_WD-1:0] hdr_din, hdr_dout;

   assign hdr_free = ~valid_hdr | ready_hdr;
   assign hdr_push = acc & (state == ST_FIRST);
   assign hdr_din  = {keep_ones(n_q), data_in & keep_mask(keep_ones(n_q))};

   axis_out_reg #(.W(DATA_WD+DATA_BYTE_WD)) u_hdr_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (hdr_push),
      .din   (hdr_din),
      .valid (valid_hdr),
      .dout  (hdr_dout),
      .ready (ready_hdr)
   );
   assign {keep_hdr, data_hdr} = hdr_dout;
`else
   // Header bytes are simply dropped, so the first beat never waits on them.
   assign hdr_free = 1'b1;
`endif

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Bench for axi_stream_strip_header: directed table, ready toggling, random packets, mid-packet reset.
// Header side stream is checked when STRIP_HDR_OUT_EN is defined.
module tb_axi_stream_strip_header;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid_cfg = 1'b0;
   logic [1:0]  strip_cnt = '0;
   logic        ready_cfg;
   logic        valid_in = 1'b0;
   logic [31:0] data_in = '0;
   logic [3:0]  keep_in = '0;
   logic        last_in = 1'b0;
   logic        ready_in;
   logic        valid_out;
   logic [31:0] data_out;
   logic [3:0]  keep_out;
   logic        last_out;
   logic        ready_out = 1'b1;
   logic [1:0]  dbg_state;
`ifdef STRIP_HDR_OUT_EN
   logic        valid_hdr;
   logic [31:0] data_hdr;
   logic [3:0]  keep_hdr;
   logic        ready_hdr = 1'b1;
`endif

   int errors = 0;
   int checks = 0;
   int ready_mode = 0;
   logic [36:0] exp_q[$];
   logic [35:0] hdr_q[$];

   typedef struct {
      int              n;
      int              nb;
      logic [2:0][31:0] d;
      logic [2:0][3:0]  k;
      int              ne;
      logic [2:0][36:0] e;
      logic [35:0]      h;
   } vec_t;
   vec_t tbl[4];

   always #5 clk = ~clk;

   axi_stream_strip_header dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid_cfg (valid_cfg),
      .strip_cnt (strip_cnt),
      .ready_cfg (ready_cfg),
      .valid_in  (valid_in),
      .data_in   (data_in),
      .keep_in   (keep_in),
      .last_in   (last_in),
      .ready_in  (ready_in),
      .valid_out (valid_out),
      .data_out  (data_out),
      .keep_out  (keep_out),
      .last_out  (last_out),
      .ready_out (ready_out),
      .dbg_state (dbg_state)
`ifdef STRIP_HDR_OUT_EN
      ,
      .valid_hdr (valid_hdr),
      .data_hdr  (data_hdr),
      .keep_hdr  (keep_hdr),
      .ready_hdr (ready_hdr)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got timeout expected handshake", name);
   endtask

   // Downstream ready: 0 always on, 1 pattern 1,0,0,1, 2 held low, 3 random.
   initial begin
      int ph = 0;
      logic r;
      forever begin
         @(posedge clk);
         #2;
         case (ready_mode)
            1: r = ((ph % 4) == 0) || ((ph % 4) == 3);
            2: r = 1'b0;
            3: r = 1'($urandom_range(0, 1));
            default: r = 1'b1;
         endcase
         ph++;
         ready_out = r;
`ifdef STRIP_HDR_OUT_EN
         ready_hdr = r;
`endif
      end
   end

   // Scoreboard / monitor, sampled on the falling edge.
   initial begin
      logic        prev_stall = 1'b0;
      logic [36:0] prev_val = '0;
      logic [36:0] cur;
      logic [36:0] e;
      forever begin
         @(negedge clk);
         cur = {last_out, keep_out, data_out};
         if (!rst_n) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall && valid_out) check("stall_hold", 64'(cur), 64'(prev_val));
            prev_stall = valid_out && !ready_out;
            prev_val   = cur;
            if (valid_out && ready_out) begin
               if (exp_q.size() == 0) fail_now("unexpected_payload");
               else begin
                  e = exp_q.pop_front();
                  check("payload", 64'(cur), 64'(e));
               end
            end
`ifdef STRIP_HDR_OUT_EN
            if (valid_hdr && ready_hdr) begin
               if (hdr_q.size() == 0) fail_now("unexpected_header");
               else check("header", 64'({keep_hdr, data_hdr}), 64'(hdr_q.pop_front()));
            end
`endif
         end
      end
   end

   task automatic do_cfg(input int n);
      int t = 0;
      valid_cfg = 1'b1;
      strip_cnt = 2'(n);
      while (1) begin
         @(negedge clk);
         if (ready_cfg) break;
         t++;
         if (t > 200) begin
            fail_now("cfg_timeout");
            break;
         end
      end
      @(posedge clk);
      #1 valid_cfg = 1'b0;
   endtask

   task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
      int t = 0;
      valid_in = 1'b1;
      data_in  = d;
      keep_in  = k;
      last_in  = l;
      while (1) begin
         @(negedge clk);
         if (ready_in) break;
         t++;
         if (t > 200) begin
            fail_now("beat_timeout");
            break;
         end
      end
      @(posedge clk);
      #1 valid_in = 1'b0;
   endtask

   task automatic send_pkt(input int n, input int nb, input logic [2:0][31:0] d,
                           input logic [2:0][3:0] k);
      do_cfg(n);
      for (int b = 0; b < nb; b++) drive_beat(d[b], k[b], b == nb - 1);
   endtask

   // Reference: header = first n bytes; payload = remaining bytes repacked MSB-first.
   task automatic model_pkt(input int n, input int nb, input logic [2:0][31:0] d,
                            input logic [2:0][3:0] k);
      logic [7:0]  bq[$];
      logic [31:0] od;
      logic [3:0]  ok;
      logic [31:0] hd = '0;
      logic [3:0]  hk = '0;
      for (int b = 0; b < nb; b++)
         for (int i = 0; i < 4; i++)
            if (k[b][3-i]) bq.push_back(d[b][31-8*i -: 8]);
      for (int i = 0; i < n; i++) begin
         hd[31-8*i -: 8] = d[0][31-8*i -: 8];
         hk[3-i] = 1'b1;
      end
      hdr_q.push_back({hk, hd});
      for (int i = 0; i < n; i++) void'(bq.pop_front());
      while (bq.size() > 0) begin
         od = '0;
         ok = '0;
         for (int i = 0; i < 4 && bq.size() > 0; i++) begin
            od[31-8*i -: 8] = bq.pop_front();
            ok[3-i] = 1'b1;
         end
         exp_q.push_back({bq.size() == 0, ok, od});
      end
   endtask

   task automatic wait_drain();
      int t = 0;
      while (exp_q.size() != 0
`ifdef STRIP_HDR_OUT_EN
             || hdr_q.size() != 0
`endif
            ) begin
         @(negedge clk);
         t++;
         if (t > 500) begin
            fail_now("drain_timeout");
            exp_q.delete();
            hdr_q.delete();
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [2:0][31:0] rd;
      logic [2:0][3:0]  rk;
      logic [3:0]       kk;
      int rn, rb, kc;

      tbl[0] = '{1, 3, {32'h55667788, 32'h11223344, 32'hAABBCCDD}, {4'hF, 4'hF, 4'hF}, 3,
                 {{1'b1, 4'hE, 32'h66778800}, {1'b0, 4'hF, 32'h22334455}, {1'b0, 4'hF, 32'hBBCCDD11}},
                 {4'h8, 32'hAA000000}};
      tbl[1] = '{2, 1, {32'h0, 32'h0, 32'hAABBCCDD}, {4'h0, 4'h0, 4'hF}, 1,
                 {37'h0, 37'h0, {1'b1, 4'hC, 32'hCCDD0000}}, {4'hC, 32'hAABB0000}};
      tbl[2] = '{3, 1, {32'h0, 32'h0, 32'h010203EE}, {4'h0, 4'h0, 4'hE}, 0,
                 {37'h0, 37'h0, 37'h0}, {4'hE, 32'h01020300}};
      tbl[3] = '{2, 2, {32'h0, 32'h05000000, 32'h01020304}, {4'h0, 4'h8, 4'hF}, 1,
                 {37'h0, 37'h0, {1'b1, 4'hE, 32'h03040500}}, {4'hC, 32'h01020000}};

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid_out", 64'(valid_out), 64'(0));
      check("rst_data_out", 64'(data_out), 64'(0));
      check("rst_keep_out", 64'(keep_out), 64'(0));
      check("rst_last_out", 64'(last_out), 64'(0));
      check("rst_ready_cfg", 64'(ready_cfg), 64'(1));
      check("rst_ready_in", 64'(ready_in), 64'(0));
      check("rst_state", 64'(dbg_state), 64'(0));
`ifdef STRIP_HDR_OUT_EN
      check("rst_valid_hdr", 64'(valid_hdr), 64'(0));
`endif
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed table
      for (int t = 0; t < 4; t++) begin
`ifdef STRIP_HDR_OUT_EN
         hdr_q.push_back(tbl[t].h);
`endif
         for (int j = 0; j < tbl[t].ne; j++) exp_q.push_back(tbl[t].e[j]);
         send_pkt(tbl[t].n, tbl[t].nb, tbl[t].d, tbl[t].k);
         if (tbl[t].nb == 1) check("cfg_ready_after_single", 64'(ready_cfg), 64'(1));
         wait_drain();
         check("idle_after_pkt", 64'(dbg_state), 64'(0));
      end

      // Same packet as the first row with downstream ready toggling 1,0,0,1
      ready_mode = 1;
`ifdef STRIP_HDR_OUT_EN
      hdr_q.push_back(tbl[0].h);
`endif
      for (int j = 0; j < tbl[0].ne; j++) exp_q.push_back(tbl[0].e[j]);
      send_pkt(tbl[0].n, tbl[0].nb, tbl[0].d, tbl[0].k);
      wait_drain();

      // Random packets against the reference model, random downstream ready
      ready_mode = 3;
      for (int p = 0; p < 25; p++) begin
         rn = $urandom_range(0, 3);
         rb = $urandom_range(1, 3);
         for (int b = 0; b < 3; b++) begin
            rd[b] = $urandom;
            rk[b] = 4'hF;
         end
         kc = (rb == 1) ? $urandom_range((rn == 0) ? 1 : rn, 4) : $urandom_range(1, 4);
         kk = 4'hF;
         kk = kk << (4 - kc);
         rk[rb-1] = kk;
`ifndef STRIP_HDR_OUT_EN
         model_pkt(rn, rb, rd, rk);
         hdr_q.delete();
`else
         model_pkt(rn, rb, rd, rk);
`endif
         send_pkt(rn, rb, rd, rk);
      end
      wait_drain();

      // Reset while in BODY with the output stalled
      ready_mode = 2;
      @(posedge clk);
      #3;
      do_cfg(1);
      drive_beat(32'hAABBCCDD, 4'hF, 1'b0);
      drive_beat(32'h11223344, 4'hF, 1'b0);
      repeat (2) @(negedge clk);
      check("pre_rst_state_body", 64'(dbg_state), 64'(2));
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid_out", 64'(valid_out), 64'(0));
      check("mid_rst_last_out", 64'(last_out), 64'(0));
      check("mid_rst_ready_cfg", 64'(ready_cfg), 64'(1));
      check("mid_rst_state", 64'(dbg_state), 64'(0));
      exp_q.delete();
      hdr_q.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      ready_mode = 0;
      @(posedge clk);
      #3;
`ifdef STRIP_HDR_OUT_EN
      hdr_q.push_back(tbl[0].h);
`endif
      for (int j = 0; j < tbl[0].ne; j++) exp_q.push_back(tbl[0].e[j]);
      send_pkt(tbl[0].n, tbl[0].nb, tbl[0].d, tbl[0].k);
      wait_drain();

      check("payload_queue_empty", 64'(exp_q.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
